serial_master_if: RTL and testbench

- Master-side bus interface that sits directly downstream of the demo top's d1_* request port.
- Accepts one parallel read or write request (address, write data, mode) per valid/ready handshake.
- Arbitrates for the serial system bus, then shifts the address and write data out bit-serially.
- For reads, shifts the returned data in and presents it as parallel d_rdata. Completion is signalled by d_ready returning high.

---
 rtl/serial_master_if_pkg.sv | 25 ++
 rtl/serial_shift_reg.sv | 41 ++++
 rtl/serial_master_if.sv | 192 +++++++++++++++++++
 tb/tb_serial_master_if.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/serial_master_if_pkg.sv
// rtl/serial_master_if_pkg.sv - shared state encoding, mode and bit-order constants for serial_master_if
package serial_master_if_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    ADDR     = 3'd2,
    ACK_WAIT = 3'd3,
    WDATA    = 3'd4,
    RDATA    = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam bit BUS_LSB_FIRST = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// rtl/serial_shift_reg.sv - loadable shift register with serial out and enable-qualified serial in
module serial_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             shift_in,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_next,
  output logic             shift_out
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    if (LSB_FIRST) begin
      shifted   = {shift_in, data[WIDTH-1:1]};
      shift_out = data[0];
    end else begin
      shifted   = {data[WIDTH-2:0], shift_in};
      shift_out = data[WIDTH-1];
    end
  end

  // data_next lets the owner capture the post-shift word on the same edge
  always_comb begin
    if (load)          data_next = load_data;
    else if (shift_en) data_next = shifted;
    else               data_next = data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data <= '0;
    else     data <= data_next;
  end

endmodule

// File: rtl/serial_master_if.sv
// rtl/serial_master_if.sv - parallel request to bit-serial bus master with arbitration, ack timeout and abort
module serial_master_if
  import serial_master_if_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic                  d_mode,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  m_req,
  input  logic                  m_grant,
  output logic                  m_mode,
  output logic                  m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_ack,
  input  logic                  m_rdata,
  input  logic                  m_rvalid
);

  localparam int CNT_W = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, ACK_TIMEOUT + 1));
  localparam int TX_W  = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;

  logic                  in_bus_phase;
  logic                  abort;
  logic                  tx_load;
  logic                  tx_shift;
  logic                  tx_sout;
  logic                  rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [TX_W-1:0]       tx_par_unused;
  logic [TX_W-1:0]       tx_next_unused;
  logic [DATA_WIDTH-1:0] rx_par_unused;
  logic                  rx_sout_unused;

  // Address and write data share one register: {wdata, addr} drains addr first
  serial_shift_reg #(.WIDTH(TX_W), .LSB_FIRST(BUS_LSB_FIRST)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data ({d_wdata, d_addr}),
    .shift_en  (tx_shift),
    .shift_in  (1'b0),
    .data      (tx_par_unused),
    .data_next (tx_next_unused),
    .shift_out (tx_sout)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH), .LSB_FIRST(BUS_LSB_FIRST)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data ('0),
    .shift_en  (rx_shift),
    .shift_in  (m_rdata),
    .data      (rx_par_unused),
    .data_next (rx_next),
    .shift_out (rx_sout_unused)
  );

  always_comb begin
    in_bus_phase = (state == ADDR) || (state == ACK_WAIT) ||
                   (state == WDATA) || (state == RDATA);
    // A same-cycle ack beats the timeout; grant loss beats everything
    abort = in_bus_phase &&
            (!m_grant || ((state == ACK_WAIT) && !m_ack && (cnt == ACK_LAST)));
    tx_load  = (state == IDLE) && d_valid;
    tx_shift = 1'b0;
    if (!abort) begin
      case (state)
        REQ:      tx_shift = m_grant;
        ADDR:     tx_shift = (cnt != ADDR_LAST);
        ACK_WAIT: tx_shift = m_ack && (mode_q == MODE_WRITE);
        WDATA:    tx_shift = (cnt != DATA_LAST);
        default:  tx_shift = 1'b0;
      endcase
    end
    rx_shift = !abort && (state == RDATA) && m_rvalid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_q   <= MODE_READ;
      d_ready  <= 1'b1;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      m_req    <= 1'b0;
      m_mode   <= MODE_READ;
      m_wdata  <= 1'b0;
      m_wvalid <= 1'b0;
    end else begin
      d_err    <= 1'b0;
      m_wvalid <= tx_shift;
      m_wdata  <= tx_shift & tx_sout;
      if (abort) begin
        state   <= IDLE;
        cnt     <= '0;
        d_err   <= 1'b1;
        d_ready <= 1'b1;
        m_req   <= 1'b0;
        m_mode  <= MODE_READ;
      end else begin
        case (state)
          IDLE: begin
            d_ready <= 1'b1;
            if (d_valid) begin
              state   <= REQ;
              cnt     <= '0;
              mode_q  <= d_mode;
              d_ready <= 1'b0;
              m_req   <= 1'b1;
            end
          end
          REQ: begin
            if (m_grant) begin
              state  <= ADDR;
              cnt    <= '0;
              m_mode <= mode_q;
            end
          end
          ADDR: begin
            if (cnt == ADDR_LAST) begin
              state <= ACK_WAIT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACK_WAIT: begin
            if (m_ack) begin
              state <= (mode_q == MODE_WRITE) ? WDATA : RDATA;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WDATA: begin
            if (cnt == DATA_LAST) begin
              state <= DONE;
              cnt   <= '0;
              m_req <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RDATA: begin
            if (m_rvalid) begin
              if (cnt == DATA_LAST) begin
                state   <= DONE;
                cnt     <= '0;
                m_req   <= 1'b0;
                d_rdata <= rx_next;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          DONE: begin
            state   <= IDLE;
            cnt     <= '0;
            d_ready <= 1'b1;
            m_mode  <= MODE_READ;
          end
          default: begin
            state   <= IDLE;
            cnt     <= '0;
            d_ready <= 1'b1;
            m_req   <= 1'b0;
            m_mode  <= MODE_READ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_master_if.sv
// tb/tb_serial_master_if.sv - directed scoreboard bench for serial_master_if
module tb_serial_master_if;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid;
  logic        d_ready;
  logic        d_mode;
  logic [15:0] d_addr;
  logic [7:0]  d_wdata;
  logic [7:0]  d_rdata;
  logic        d_err;
  logic        m_req;
  logic        m_grant;
  logic        m_mode;
  logic        m_wdata;
  logic        m_wvalid;
  logic        m_ack;
  logic        m_rdata;
  logic        m_rvalid;

  int checks   = 0;
  int failures = 0;

  logic       exp_q[$];
  logic [7:0] rd_q[$];
  logic [7:0] model_rdata = 8'h00;

  serial_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_mode   (d_mode),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .m_req    (m_req),
    .m_grant  (m_grant),
    .m_mode   (m_mode),
    .m_wdata  (m_wdata),
    .m_wvalid (m_wvalid),
    .m_ack    (m_ack),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic accept(input logic mode, input logic [15:0] addr, input logic [7:0] wdata);
    d_addr  = addr;
    d_wdata = wdata;
    d_mode  = mode;
    d_valid = 1'b1;
    @(negedge clk);
    d_valid = 1'b0;
    d_addr  = ~addr;
    d_wdata = ~wdata;
    d_mode  = ~mode;
  endtask

  // Full transaction; position k is the negedge after the k-th edge past accept
  task automatic xact(input logic mode, input logic [15:0] addr, input logic [7:0] wdata,
                      input logic [7:0] rword, input int gdelay, input int exp_lat);
    int k;
    int nbit;
    int errs;
    logic [7:0] prev;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(addr[i]);
    if (mode) for (int i = 0; i < 8; i++) exp_q.push_back(wdata[i]);
    rd_q.push_back(mode ? model_rdata : rword);
    if (!mode) model_rdata = rword;
    m_grant  = (gdelay == 0);
    m_ack    = 1'b1;
    m_rvalid = 1'b0;
    accept(mode, addr, wdata);
    k = 0; nbit = 0; errs = 0; prev = d_rdata;
    while (!d_ready && k < 200) begin
      if (m_wvalid) begin
        if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
        else                   check("wbit", m_wdata, exp_q.pop_front());
      end
      if (gdelay > 0 && k <= gdelay) check("grant_wait", {m_req, m_wvalid}, 2'b10);
      if (k == gdelay + 1) check("addr_start", m_wvalid, 1'b1);
      if (k == gdelay) m_grant = 1'b1;
      if (!mode) begin
        if (k < 18 + gdelay) begin
          m_rvalid = 1'b1;
          m_rdata  = 1'b1;
        end else if (((k - 18 - gdelay) % 2 == 0) && nbit < 8) begin
          m_rvalid = 1'b1;
          m_rdata  = rword[nbit];
          nbit++;
        end else begin
          m_rvalid = 1'b0;
        end
      end
      if (d_err) errs++;
      prev = d_rdata;
      @(negedge clk);
      k++;
    end
    m_rvalid = 1'b0;
    check("latency", k, exp_lat);
    check("bits_left", exp_q.size(), 0);
    check("no_err", errs, 0);
    check("rdata_at_done", prev, rd_q.pop_front());
  endtask

  task automatic abort_xact(input logic mode, input logic [15:0] addr, input logic ack_low,
                            input int drop_pos, input int exp_pos, input int exp_bits);
    int k;
    int nbit;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(addr[i]);
    m_grant  = 1'b1;
    m_ack    = !ack_low;
    m_rvalid = 1'b0;
    accept(mode, addr, 8'h00);
    k = 0; nbit = 0;
    while (!d_err && k < 200) begin
      if (m_wvalid) begin
        if (exp_q.size() == 0) check("extra_bit", 32'd1, 32'd0);
        else                   check("wbit", m_wdata, exp_q.pop_front());
        nbit++;
      end
      if (k == drop_pos) m_grant = 1'b0;
      @(negedge clk);
      k++;
    end
    check("abort_pos", k, exp_pos);
    check("abort_bits", nbit, exp_bits);
    check("abort_outs", {d_ready, m_req, m_wvalid, m_mode}, 4'b1000);
    check("abort_rdata", d_rdata, model_rdata);
    m_grant = 1'b1;
    m_ack   = 1'b1;
    @(negedge clk);
    check("err_pulse", d_err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_mode = 1'b0; d_addr = '0; d_wdata = '0;
    m_grant = 1'b1; m_ack = 1'b1; m_rdata = 1'b0; m_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", d_ready, 1'b1);
    check("rst_outs", {d_err, m_req, m_mode, m_wvalid, m_wdata}, 5'b00000);
    check("rst_rdata", d_rdata, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    xact(1'b1, 16'h1001, 8'hA5, 8'h00, 0, 27);
    xact(1'b0, 16'h1001, 8'h00, 8'h3C, 0, 34);
    xact(1'b1, 16'hBEEF, 8'h5A, 8'h00, 10, 37);
    abort_xact(1'b0, 16'h1234, 1'b1, -1, 32, 16);
    xact(1'b1, 16'h00FF, 8'hC3, 8'h00, 0, 27);
    abort_xact(1'b1, 16'h8421, 1'b0, 5, 6, 5);

    m_grant = 1'b1; m_ack = 1'b1;
    accept(1'b1, 16'h2468, 8'hF0);
    repeat (20) @(negedge clk);
    check("pre_rst_wvalid", m_wvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async", {d_ready, d_err, m_req, m_mode, m_wvalid, m_wdata}, 6'b100000);
    check("rst_async_rdata", d_rdata, 8'h00);
    model_rdata = 8'h00;
    @(negedge clk);
    check("rst_no_err", d_err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_err", d_err, 1'b0);
    xact(1'b1, 16'h5555, 8'h81, 8'h00, 0, 27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
